// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: decoder/E-stage status in, PC/IF-ID/pipe control and forwarding selects out.
interface hazard_ctrl_if #(
   parameter int REG_AW = 5
);
   logic [31:0]       d_ir;
   logic [REG_AW-1:0] e_dstreg_num;
   logic              e_write_reg;
   logic [2:0]        e_info_load;
   logic [REG_AW-1:0] e_reg1_addr;
   logic [REG_AW-1:0] e_reg2_addr;
   logic              e_br_taken;
   logic              mem_wait;
   logic              stall_f;
   logic              stall_d;
   logic              flush;
   logic              freeze;
   logic [1:0]        fwd1_sel;
   logic [1:0]        fwd2_sel;

   modport master (
      input  d_ir, e_dstreg_num, e_write_reg, e_info_load, e_reg1_addr, e_reg2_addr,
             e_br_taken, mem_wait,
      output stall_f, stall_d, flush, freeze, fwd1_sel, fwd2_sel
   );

   modport slave (
      output d_ir, e_dstreg_num, e_write_reg, e_info_load, e_reg1_addr, e_reg2_addr,
             e_br_taken, mem_wait,
      input  stall_f, stall_d, flush, freeze, fwd1_sel, fwd2_sel
   );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard control: load-use stall, branch squash, mem-wait freeze, E forwarding.
// All outputs combinational (same-cycle); HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int REG_AW       = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   hazard_ctrl_if.master hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]   perf_stall_cnt,
   output logic [31:0]   perf_flush_cnt
`endif
);

   // Decoder encodes "no load" as 3'b111 since funct3 000 is a valid load (LB).
   localparam logic [2:0] NOTLOAD   = 3'b111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_B      = 7'b1100011;
   localparam logic [6:0] OP_S      = 7'b0100011;
   localparam logic [6:0] OP_L      = 7'b0000011;
   localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {RUN, LDSTALL, BRFLUSH, MWAIT} state_t;

   state_t            state, state_nxt, saved, saved_nxt, eff;
   logic [1:0]        fcnt, fcnt_nxt;
   logic [REG_AW-1:0] m_dst, w_dst;
   logic              m_wr, m_ld, w_wr;

   logic [6:0]        opc;
   logic [REG_AW-1:0] rs1, rs2;
   logic              use_rs1, use_rs2, loaduse;
   logic              stall_c, flush_c, freeze_c;
   logic              d_ir_unused;

   assign opc         = hz.d_ir[6:0];
   assign rs1         = REG_AW'(hz.d_ir[19:15]);
   assign rs2         = REG_AW'(hz.d_ir[24:20]);
   assign d_ir_unused = ^{hz.d_ir[31:25], hz.d_ir[14:7]};
   assign use_rs1     = opc inside {OP_IMM, OP_R, OP_JALR, OP_B, OP_S, OP_L};
   assign use_rs2     = opc inside {OP_R, OP_B, OP_S};

   assign loaduse = (hz.e_info_load != NOTLOAD) && hz.e_write_reg &&
                    (hz.e_dstreg_num != '0) &&
                    ((use_rs1 && hz.e_dstreg_num == rs1) ||
                     (use_rs2 && hz.e_dstreg_num == rs2));

   always_comb begin
      state_nxt = state;
      saved_nxt = saved;
      fcnt_nxt  = fcnt;
      stall_c   = 1'b0;
      flush_c   = 1'b0;
      freeze_c  = 1'b0;
      // Release cycle of a wait behaves exactly like the state it interrupted.
      eff = (state == MWAIT && !hz.mem_wait) ? saved : state;
      case (eff)
         RUN, LDSTALL: begin
            state_nxt = RUN;
            if (hz.mem_wait) begin
               stall_c   = 1'b1;
               freeze_c  = 1'b1;
               state_nxt = MWAIT;
               saved_nxt = RUN;
            end else if (hz.e_br_taken) begin
               flush_c   = 1'b1;
               fcnt_nxt  = FCNT_INIT;
               state_nxt = (FLUSH_CYCLES > 1) ? BRFLUSH : RUN;
            end else if (loaduse && eff == RUN) begin
               stall_c   = 1'b1;
               flush_c   = 1'b1;
               state_nxt = LDSTALL;
            end
         end
         BRFLUSH: begin
            flush_c = 1'b1;
            if (hz.mem_wait) begin
               stall_c   = 1'b1;
               freeze_c  = 1'b1;
               state_nxt = MWAIT;
               saved_nxt = BRFLUSH;
            end else begin
               fcnt_nxt  = (fcnt == 2'd0) ? 2'd0 : fcnt - 2'd1;
               state_nxt = (fcnt <= 2'd1) ? RUN : BRFLUSH;
            end
         end
         default: begin
            stall_c   = 1'b1;
            freeze_c  = 1'b1;
            flush_c   = (saved == BRFLUSH);
            state_nxt = MWAIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
         saved <= RUN;
         fcnt  <= '0;
         m_dst <= '0;
         m_wr  <= 1'b0;
         m_ld  <= 1'b0;
         w_dst <= '0;
         w_wr  <= 1'b0;
      end else begin
         state <= state_nxt;
         saved <= saved_nxt;
         fcnt  <= fcnt_nxt;
         if (!freeze_c) begin
            m_dst <= hz.e_dstreg_num;
            m_wr  <= hz.e_write_reg;
            m_ld  <= (hz.e_info_load != NOTLOAD);
            w_dst <= m_dst;
            w_wr  <= m_wr;
         end
      end
   end

   // A load sitting in M is never a forwarding source; load-use stall pushes it to W first.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] addr);
      if (m_wr && m_dst != '0 && m_dst == addr && !m_ld)
         return 2'b01;
      else if (w_wr && w_dst != '0 && w_dst == addr)
         return 2'b10;
      else
         return 2'b00;
   endfunction

   assign hz.stall_f  = rst_n & stall_c;
   assign hz.stall_d  = rst_n & stall_c;
   assign hz.flush    = rst_n & flush_c;
   assign hz.freeze   = rst_n & freeze_c;
   assign hz.fwd1_sel = rst_n ? fwd_sel(hz.e_reg1_addr) : 2'b00;
   assign hz.fwd2_sel = rst_n ? fwd_sel(hz.e_reg2_addr) : 2'b00;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (stall_c && !freeze_c && perf_stall_cnt != 32'hFFFF_FFFF)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (flush_c && perf_flush_cnt != 32'hFFFF_FFFF)
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then randomized traffic against a behavioural model.
module tb_hazard_ctrl;
   localparam int FC = 2;
   localparam int AW = 5;
   localparam logic [2:0] NL = 3'b111;
   localparam logic [2:0] LW = 3'b010;
   localparam logic [6:0] O_IMM = 7'b0010011, O_R = 7'b0110011, O_JALR = 7'b1100111,
                          O_B = 7'b1100011, O_S = 7'b0100011, O_L = 7'b0000011,
                          O_LUI = 7'b0110111, O_JAL = 7'b1101111;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if #(.REG_AW(AW)) hz ();
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
   hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .hz(hz),
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt));
`else
   hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_AW(AW)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
`endif

   typedef struct packed {
      logic [3:0] ctl;   // {stall_f, stall_d, flush, freeze}
      logic [3:0] fwd;   // {fwd1_sel, fwd2_sel}
   } exp_t;
   exp_t expq[$];

   typedef struct {
      bit wr;
      bit ld;
      int dst;
   } ent_t;

   // Reference model: remaining squash cycles, whether a load-use bubble was just inserted,
   // and the two older instructions (M, W) as plain records.
   int   flush_left = 0;
   bit   just_ld = 0;
   ent_t m_e = '{0, 0, 0};
   ent_t w_e = '{0, 0, 0};
   longint p_stall = 0, p_flush = 0;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int a, input int b);
      logic [4:0] rdv, av, bv;
      rdv = rd[4:0];
      av  = a[4:0];
      bv  = b[4:0];
      return {7'b0, bv, av, 3'b0, rdv, op};
   endfunction

   function automatic logic [1:0] model_fwd(input int r);
      if (m_e.wr && m_e.dst != 0 && m_e.dst == r && !m_e.ld) return 2'b01;
      if (w_e.wr && w_e.dst != 0 && w_e.dst == r) return 2'b10;
      return 2'b00;
   endfunction

   task automatic step(input logic [31:0] ir, input int dst, input logic wr, input logic [2:0] ld,
                       input int r1, input int r2, input logic br, input logic mw,
                       input logic rs = 1'b1);
      exp_t e;
      bit   u1, u2, luse, st, fl, fz;
      int   s1, s2;
      @(posedge clk);
      #1;
      rst_n              = rs;
      hz.d_ir            = ir;
      hz.e_dstreg_num    = dst[AW-1:0];
      hz.e_write_reg     = wr;
      hz.e_info_load     = ld;
      hz.e_reg1_addr     = r1[AW-1:0];
      hz.e_reg2_addr     = r2[AW-1:0];
      hz.e_br_taken      = br;
      hz.mem_wait        = mw;
      st = 0; fl = 0; fz = 0;
      if (!rs) begin
         e = '0;
         flush_left = 0;
         just_ld = 0;
         m_e = '{0, 0, 0};
         w_e = '{0, 0, 0};
         p_stall = 0;
         p_flush = 0;
      end else begin
         s1 = int'(ir[19:15]);
         s2 = int'(ir[24:20]);
         u1 = ir[6:0] inside {O_IMM, O_R, O_JALR, O_B, O_S, O_L};
         u2 = ir[6:0] inside {O_R, O_B, O_S};
         luse = (ld != NL) && wr && dst != 0 && ((u1 && dst == s1) || (u2 && dst == s2));
         e.fwd = {model_fwd(r1), model_fwd(r2)};
         if (mw) begin
            st = 1; fz = 1; fl = (flush_left > 0); just_ld = 0;
         end else if (flush_left > 0) begin
            fl = 1; flush_left--; just_ld = 0;
         end else if (br) begin
            fl = 1; flush_left = FC - 1; just_ld = 0;
         end else if (luse && !just_ld) begin
            st = 1; fl = 1; just_ld = 1;
         end else begin
            just_ld = 0;
         end
         e.ctl = {st, st, fl, fz};
         if (!fz) begin
            w_e = m_e;
            m_e = '{wr, (ld != NL), dst};
         end
         if (st && !fz) p_stall++;
         if (fl) p_flush++;
      end
      expq.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      logic [3:0] act_ctl, act_fwd;
      if (expq.size() != 0) begin
         e = expq.pop_front();
         act_ctl = {hz.stall_f, hz.stall_d, hz.flush, hz.freeze};
         act_fwd = {hz.fwd1_sel, hz.fwd2_sel};
         n_cmp++;
         if (act_ctl !== e.ctl) begin
            n_bad++;
            $display("FAIL ctrl t=%0t got sf/sd/fl/fz=%b want %b", $time, act_ctl, e.ctl);
         end
         n_cmp++;
         if (act_fwd !== e.fwd) begin
            n_bad++;
            $display("FAIL fwd t=%0t got f1/f2=%b want %b", $time, act_fwd, e.fwd);
         end
      end
   end

   logic [6:0] ops [8] = '{O_IMM, O_R, O_JALR, O_B, O_S, O_L, O_LUI, O_JAL};

   initial begin
      logic [31:0] nop;
      nop = mk(O_IMM, 0, 0, 0);
      hz.d_ir = '0; hz.e_dstreg_num = '0; hz.e_write_reg = 0; hz.e_info_load = NL;
      hz.e_reg1_addr = '0; hz.e_reg2_addr = '0; hz.e_br_taken = 0; hz.mem_wait = 0;

      // reset, then quiet pipe
      step(nop, 0, 0, NL, 0, 0, 0, 0, 0);
      step(nop, 0, 0, NL, 0, 0, 0, 0, 0);
      step(nop, 0, 0, NL, 0, 0, 0, 0);

      // lw x5 in E, add x6,x5,x7 in D: one-cycle stall, then add forwards from W
      step(mk(O_R, 6, 5, 7), 5, 1, LW, 1, 2, 0, 0);
      step(mk(O_R, 6, 5, 7), 0, 0, NL, 0, 0, 0, 0);
      step(nop, 6, 1, NL, 5, 7, 0, 0);

      // lw x0 with D reading x0: no hazard
      step(mk(O_R, 1, 0, 0), 0, 1, LW, 0, 0, 0, 0);

      // taken branch with coincident load-use in D
      step(mk(O_R, 1, 4, 0), 4, 1, LW, 0, 0, 1, 0);
      step(mk(O_R, 1, 4, 0), 4, 1, LW, 0, 0, 0, 0);
      step(nop, 0, 0, NL, 0, 0, 0, 0);

      // add x3 -> W, addi x3 -> M, E reads x3 twice
      step(nop, 3, 1, NL, 0, 0, 0, 0);
      step(nop, 3, 1, NL, 0, 0, 0, 0);
      step(nop, 0, 0, NL, 3, 3, 0, 0);
      step(nop, 0, 0, NL, 3, 3, 0, 0);

      // mem_wait during second squash cycle: tracking must not capture x7
      step(nop, 0, 0, NL, 0, 0, 1, 0);
      repeat (3) step(nop, 7, 1, NL, 7, 7, 0, 1);
      step(nop, 0, 0, NL, 7, 7, 0, 0);
      step(nop, 0, 0, NL, 7, 7, 0, 0);

      // reset while in the load-use stall cycle
      step(mk(O_R, 1, 5, 0), 5, 1, LW, 0, 0, 0, 0);
      step(mk(O_R, 1, 5, 0), 5, 1, LW, 5, 5, 0, 0, 0);
      step(nop, 0, 0, NL, 5, 5, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         step(mk(ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3)),
              $urandom_range(0, 3), ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 2) == 0) ? LW : NL,
              $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 199) != 0));
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (expq.size() != 0) begin
         n_bad++;
         $display("FAIL drain got %0d pending want 0", expq.size());
      end
`ifdef HAZARD_PERF_CNT_EN
      n_cmp++;
      if (perf_stall_cnt !== 32'(p_stall)) begin
         n_bad++;
         $display("FAIL perf_stall got %0d want %0d", perf_stall_cnt, p_stall);
      end
      n_cmp++;
      if (perf_flush_cnt !== 32'(p_flush)) begin
         n_bad++;
         $display("FAIL perf_flush got %0d want %0d", perf_flush_cnt, p_flush);
      end
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
